// File: rtl/micro_waves_ctrl_gen.sv
// micro_waves_ctrl_gen: microwave controller - keypad BCD time entry, countdown, door interlock, pause/resume, power duty cycling.
// Latency: button/key events act on the edge that samples them; the countdown decrements once every CLK_DIV cycles in COOK.
// Backpressure: none; inputs are sampled every cycle and all outputs are always valid.
//
// Optional feature: define QUICK_START_EN for quick start (start at 0:00 loads 0:30) and +30 s on start while cooking.
// Ports: clk, resetn (async, active-low); startn/stopn/clearn active-low buttons; door_closed (1 = closed);
//        keypad one-hot digit keys; power_key; sec_ones/sec_tens/minutes BCD time; power level;
//        mag_on magnetron enable; done cook-finished flag; state (IDLE=0, COOK=1, PAUSE=2, DONE=3).
module micro_waves_ctrl_gen #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int MIN_DIGITS = 1,
    parameter int PWR_WINDOW = 10
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            startn,
    input  logic                            stopn,
    input  logic                            clearn,
    input  logic                            door_closed,
    input  logic [9:0]                      keypad,
    input  logic                            power_key,
    output logic [3:0]                      sec_ones,
    output logic [3:0]                      sec_tens,
    output logic [4*MIN_DIGITS-1:0]         minutes,
    output logic [$clog2(PWR_WINDOW+1)-1:0] power,
    output logic                            mag_on,
    output logic                            done,
    output logic [1:0]                      state
);
    localparam int PW = $clog2(PWR_WINDOW + 1);
    localparam int DW = $clog2(CLK_DIV);
    localparam int MW = 4 * MIN_DIGITS;

    typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    state_t        st;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] win_cnt;
    logic          start_q, stop_q, clear_q, pkey_q;
    logic [9:0]    kp_q;

    // Edge detection against the previous sample.
    logic start_ev, stop_ev, clear_ev, pkey_ev, key_ev;
    assign start_ev = start_q & ~startn;
    assign stop_ev  = stop_q & ~stopn;
    assign clear_ev = clear_q & ~clearn;
    assign pkey_ev  = ~pkey_q & power_key;
    // Multi-key words never fire, and since kp_q then holds a non-zero word the keypad must return to 0 first.
    assign key_ev   = (kp_q == 10'd0) && $onehot(keypad);

    logic [3:0] key_val;
    always_comb begin
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_val = 4'(i);
        end
    end

    // Entry shift: minutes move up one digit, sec_tens enters minute digit 0.
    logic [MW-1:0] min_shift;
    always_comb begin
        min_shift = '0;
        min_shift[3:0] = sec_tens;
        for (int i = 1; i < MIN_DIGITS; i++) begin
            min_shift[4*i +: 4] = minutes[4*(i-1) +: 4];
        end
    end

    // One-second decrement with BCD borrow through seconds then minutes.
    logic [3:0]    dec_ones, dec_tens;
    logic [MW-1:0] dec_min;
    logic          dec_borrow;
    always_comb begin
        dec_ones   = sec_ones;
        dec_tens   = sec_tens;
        dec_min    = minutes;
        dec_borrow = 1'b0;
        if (sec_ones != 4'd0) begin
            dec_ones = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            dec_tens = sec_tens - 4'd1;
            dec_ones = 4'd9;
        end else begin
            dec_tens   = 4'd5;
            dec_ones   = 4'd9;
            dec_borrow = 1'b1;
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (dec_borrow) begin
                    if (minutes[4*i +: 4] == 4'd0) begin
                        dec_min[4*i +: 4] = 4'd9;
                    end else begin
                        dec_min[4*i +: 4] = minutes[4*i +: 4] - 4'd1;
                        dec_borrow        = 1'b0;
                    end
                end
            end
        end
    end

    logic dec_zero, time_zero, tick;
    assign dec_zero  = (dec_min == '0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    assign time_zero = (minutes == '0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign tick      = (div_cnt == DW'(CLK_DIV - 1));

`ifdef QUICK_START_EN
    // +30 s: tens digit +3 with carry at 6 into the minutes; add_carry left set after the loop means overflow.
    logic [4:0]    add_tens_sum;
    logic [3:0]    add_tens;
    logic [MW-1:0] add_min;
    logic          add_carry;
    always_comb begin
        add_tens_sum = {1'b0, sec_tens} + 5'd3;
        add_tens     = add_tens_sum[3:0];
        add_carry    = 1'b0;
        if (add_tens_sum >= 5'd6) begin
            add_tens  = 4'(add_tens_sum - 5'd6);
            add_carry = 1'b1;
        end
        add_min = minutes;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (add_carry) begin
                if (minutes[4*i +: 4] >= 4'd9) begin
                    add_min[4*i +: 4] = 4'd0;
                end else begin
                    add_min[4*i +: 4] = minutes[4*i +: 4] + 4'd1;
                    add_carry         = 1'b0;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st       <= IDLE;
            sec_ones <= '0;
            sec_tens <= '0;
            minutes  <= '0;
            power    <= PW'(PWR_WINDOW);
            done     <= 1'b0;
            div_cnt  <= '0;
            win_cnt  <= '0;
            start_q  <= 1'b1;
            stop_q   <= 1'b1;
            clear_q  <= 1'b1;
            pkey_q   <= 1'b0;
            kp_q     <= '0;
        end else begin
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
            pkey_q  <= power_key;
            kp_q    <= keypad;
            if (clear_ev) begin
                st       <= IDLE;
                sec_ones <= '0;
                sec_tens <= '0;
                minutes  <= '0;
                done     <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (start_ev && !stop_ev) begin
                            if (door_closed && !time_zero) begin
                                st      <= COOK;
                                div_cnt <= '0;
                                win_cnt <= '0;
                            end
`ifdef QUICK_START_EN
                            else if (door_closed) begin
                                sec_tens <= 4'd3;
                                sec_ones <= 4'd0;
                                st       <= COOK;
                                div_cnt  <= '0;
                                win_cnt  <= '0;
                            end
`endif
                        end else if (!stop_ev) begin
                            if (key_ev) begin
                                minutes  <= min_shift;
                                sec_tens <= sec_ones;
                                sec_ones <= key_val;
                            end
                            if (pkey_ev) begin
                                power <= (power <= PW'(1)) ? PW'(PWR_WINDOW) : power - PW'(1);
                            end
                        end
                    end
                    COOK: begin
                        // stop / door open outrank the tick: no decrement on that edge.
                        if (stop_ev || !door_closed) begin
                            st <= PAUSE;
                        end
`ifdef QUICK_START_EN
                        else if (start_ev) begin
                            if (add_carry) begin
                                minutes  <= {MIN_DIGITS{4'd9}};
                                sec_tens <= 4'd9;
                                sec_ones <= 4'd9;
                            end else begin
                                minutes  <= add_min;
                                sec_tens <= add_tens;
                            end
                        end
`endif
                        else if (tick) begin
                            div_cnt  <= '0;
                            win_cnt  <= (win_cnt == PW'(PWR_WINDOW - 1)) ? '0 : win_cnt + PW'(1);
                            sec_ones <= dec_ones;
                            sec_tens <= dec_tens;
                            minutes  <= dec_min;
                            if (dec_zero) begin
                                st   <= DONE;
                                done <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt + DW'(1);
                        end
                    end
                    PAUSE: begin
                        // Divider and window counter hold; resume continues from the frozen count.
                        if (stop_ev) begin
                            st       <= IDLE;
                            sec_ones <= '0;
                            sec_tens <= '0;
                            minutes  <= '0;
                        end else if (start_ev && door_closed) begin
                            st <= COOK;
                        end
                    end
                    DONE: begin
                        if (stop_ev || !door_closed || start_ev || key_ev || pkey_ev) begin
                            st   <= IDLE;
                            done <= 1'b0;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    // Door term is combinational so the magnetron drops in the cycle the door opens.
    assign mag_on = (st == COOK) && door_closed && (win_cnt < power);
    assign state  = st;

endmodule

// File: tb/tb_micro_waves_ctrl_gen.sv
`timescale 1ns/1ps
module tb_micro_waves_ctrl_gen;
    localparam logic [1:0] S_IDLE = 2'd0, S_COOK = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       resetn, startn, stopn, clearn, door_closed, power_key;
    logic [9:0] keypad;
    logic [3:0] sec_ones, sec_tens, minutes, power;
    logic       mag_on, done;
    logic [1:0] state;

    micro_waves_ctrl_gen #(.CLK_DIV(4), .MIN_DIGITS(1), .PWR_WINDOW(10)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .keypad(keypad), .power_key(power_key),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .minutes(minutes), .power(power),
        .mag_on(mag_on), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] mn;
        logic [3:0] tn;
        logic [3:0] on;
        logic [3:0] pw;
        logic       mg;
        logic       dn;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0;
    int          passed = 0;
    logic [19:0] act, req;

    task automatic push_exp(input string n, input logic [1:0] s, input logic [3:0] m, input logic [3:0] t,
                            input logic [3:0] o, input logic [3:0] p, input logic mg, input logic dn);
        exp_t e;
        e.name = n; e.st = s; e.mn = m; e.tn = t; e.on = o; e.pw = p; e.mg = mg; e.dn = dn;
        exp_q.push_back(e);
    endtask

    // Monitor: the expectation pushed before an edge is compared 2 ns after that edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            act = {state, minutes, sec_tens, sec_ones, power, mag_on, done};
            req = {cur.st, cur.mn, cur.tn, cur.on, cur.pw, cur.mg, cur.dn};
            checks++;
            if (act === req) passed++;
            else $display("FAIL %s: got st=%0d time=%h:%h%h pwr=%0d mag=%b done=%b, required st=%0d time=%h:%h%h pwr=%0d mag=%b done=%b",
                          cur.name, state, minutes, sec_tens, sec_ones, power, mag_on, done,
                          cur.st, cur.mn, cur.tn, cur.on, cur.pw, cur.mg, cur.dn);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input int d);
        @(negedge clk); keypad = 10'(1 << d);
        @(negedge clk); keypad = '0;
    endtask

    // 0 = start, 1 = stop, 2 = clear, 3 = power_key
    task automatic press(input int b);
        @(negedge clk);
        case (b)
            0: startn = 1'b0;
            1: stopn = 1'b0;
            2: clearn = 1'b0;
            default: power_key = 1'b1;
        endcase
        @(negedge clk);
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; power_key = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; keypad = '0; power_key = 1'b0;
        @(negedge clk);
        push_exp("reset", S_IDLE, 0, 0, 0, 10, 0, 0);
        @(negedge clk); resetn = 1'b1;

        // Entry 1:25, cook to completion
        key(1); key(2); key(5);
        push_exp("entry_125", S_IDLE, 1, 2, 5, 10, 0, 0);
        press(0);
        push_exp("cook_entry", S_COOK, 1, 2, 5, 10, 1, 0);
        cyc(2); push_exp("pre_tick", S_COOK, 1, 2, 5, 10, 1, 0);
        cyc(1); push_exp("tick1", S_COOK, 1, 2, 4, 10, 1, 0);
        cyc(335); push_exp("pre_done", S_COOK, 0, 0, 1, 10, 1, 0);
        cyc(1); push_exp("done", S_DONE, 0, 0, 0, 10, 0, 1);
        press(1);
        push_exp("done_exit", S_IDLE, 0, 0, 0, 10, 0, 0);

        // Door interlock at 1:00, pause, resume
        key(1); key(0); key(0);
        push_exp("entry_100", S_IDLE, 1, 0, 0, 10, 0, 0);
        press(0);
        push_exp("cook_100", S_COOK, 1, 0, 0, 10, 1, 0);
        @(posedge clk); @(posedge clk); #1 door_closed = 1'b0;
        push_exp("door_comb", S_COOK, 1, 0, 0, 10, 0, 0);
        @(negedge clk); push_exp("door_pause", S_PAUSE, 1, 0, 0, 10, 0, 0);
        cyc(3); push_exp("pause_frozen", S_PAUSE, 1, 0, 0, 10, 0, 0);
        @(negedge clk); door_closed = 1'b1; startn = 1'b0;
        @(negedge clk); startn = 1'b1;
        push_exp("resume", S_COOK, 1, 0, 0, 10, 1, 0);
        @(negedge clk); push_exp("resume_tick", S_COOK, 0, 5, 9, 10, 1, 0);

        // Stop to PAUSE, stop again to IDLE
        press(1); push_exp("stop_pause", S_PAUSE, 0, 5, 9, 10, 0, 0);
        press(1); push_exp("stop_idle", S_IDLE, 0, 0, 0, 10, 0, 0);

        // Power 10 -> 3, clear mid-cook keeps power
        for (int i = 0; i < 7; i++) press(3);
        push_exp("power3", S_IDLE, 0, 0, 0, 3, 0, 0);
        key(4); key(2);
        push_exp("entry_042", S_IDLE, 0, 4, 2, 3, 0, 0);
        press(0); push_exp("cook_042", S_COOK, 0, 4, 2, 3, 1, 0);
        press(2); push_exp("clear_cook", S_IDLE, 0, 0, 0, 3, 0, 0);

        // Duty cycle: power 3 of 10, one sample per tick period across a window wrap
        key(2); key(0);
        push_exp("entry_020", S_IDLE, 0, 2, 0, 3, 0, 0);
        press(0);
        for (int j = 0; j <= 10; j++) begin
            push_exp($sformatf("duty_%0d", j), S_COOK, 4'd0, 4'((20 - j) / 10), 4'((20 - j) % 10),
                     4'd3, (j % 10) < 3, 1'b0);
            if (j < 10) cyc(4);
        end

        // Asynchronous reset mid-cook
        @(posedge clk); @(posedge clk); #1 resetn = 1'b0;
        push_exp("async_reset", S_IDLE, 0, 0, 0, 10, 0, 0);
        @(negedge clk); resetn = 1'b1;
        push_exp("reset_release", S_IDLE, 0, 0, 0, 10, 0, 0);

        // Clear beats start; multi-key word ignored; sec_tens may exceed 5
        key(5); push_exp("entry_005", S_IDLE, 0, 0, 5, 10, 0, 0);
        @(negedge clk); startn = 1'b0; clearn = 1'b0;
        @(negedge clk); startn = 1'b1; clearn = 1'b1;
        push_exp("start_clear", S_IDLE, 0, 0, 0, 10, 0, 0);
        key(7); push_exp("entry_007", S_IDLE, 0, 0, 7, 10, 0, 0);
        @(negedge clk); keypad = 10'b0000000011;
        @(negedge clk); keypad = '0;
        push_exp("multikey", S_IDLE, 0, 0, 7, 10, 0, 0);
        key(4); push_exp("entry_074", S_IDLE, 0, 7, 4, 10, 0, 0);

        // Power wrap 1 -> PWR_WINDOW
        for (int i = 0; i < 9; i++) press(3);
        push_exp("power1", S_IDLE, 0, 7, 4, 1, 0, 0);
        press(3); push_exp("power_wrap", S_IDLE, 0, 7, 4, 10, 0, 0);
        press(2); push_exp("clr", S_IDLE, 0, 0, 0, 10, 0, 0);

        // Start at 0:00
        press(0);
`ifdef QUICK_START_EN
        push_exp("quick_start", S_COOK, 0, 3, 0, 10, 1, 0);
        cyc(20);
        press(0); push_exp("quick_add", S_COOK, 0, 5, 5, 10, 1, 0);
        press(2); push_exp("quick_clr", S_IDLE, 0, 0, 0, 10, 0, 0);
`else
        push_exp("start_zero", S_IDLE, 0, 0, 0, 10, 0, 0);
`endif

        cyc(3);
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain: %0d expectations unchecked, required 0", exp_q.size());
            checks += exp_q.size();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
